crc_engine: RTL and testbench
=============================

Name: crc_engine

Overview:
Parametrised successor of the single-bit, register-configured CRC generator. Streaming CRC engine on the ICB register bus: programmable width (8..CW in byte steps), polynomial, init, final XOR, input/output reflection, leading-byte skip. Consumes DW data bits per clock over a valid/ready stream and delivers a frame CRC over a valid/ready result port. Sits beside the packet datapath as a checker/generator, configured by the CPU.

Parameters:
CW, 32, maximum CRC width in bits; multiple of 8, 8..32
DW, 8, data bits accepted per beat; 1, 8 or 16; CW/DW frames need not divide
AW, 8, ICB address width

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous reset, active-high
icb_wr  in  1  register write strobe
icb_wadr  in  AW  write address
icb_wdat  in  32  write data
icb_wack  out  1  write ack (= icb_wr, same cycle)
icb_rd  in  1  register read strobe
icb_radr  in  AW  read address
icb_rdat  out  32  read data, combinational from registers
icb_rack  out  1  read ack (= icb_rd, same cycle)
in_vld  in  1  data beat valid
in_rdy  out  1  engine accepts beat
in_dat  in  DW  data beat
in_last  in  1  final beat of frame
out_vld  out  1  CRC result valid
out_rdy  in  1  result consumer ready
out_crc  out  CW  final CRC, zero-extended above active width

Behaviour:
- Register map (word addr): 0 CON rw, 1 POLY rw, 2 INIT rw, 3 XOROUT rw, 4 RESULT ro, 5 STATUS (ro bits, W1C err). Unmapped reads return 0; unmapped writes ignored.
- CON: [0] en, [3:1] len bytes (W=8*len), [4] refin, [5] refout, [7:6] skip bytes (0..3). POLY/INIT/XOROUT: low W bits used, bits >= W ignored.
- STATUS: [0] busy (state RUN), [1] done (state DONE), [2] err sticky; writing 1 to bit 2 clears err.
- Reset: all registers 0, state IDLE, lfsr 0, in_rdy 0, out_vld 0, out_crc 0, RESULT 0.
- FSM: IDLE (en=0 or no frame yet), RUN, DONE. IDLE->RUN on en=1 (lfsr<=INIT, skip counter<=skip*8). RUN: in_rdy=1; each accepted beat updates lfsr by DW serial steps in one cycle. Accepted beat with in_last -> DONE. DONE: in_rdy=0, out_vld=1, out_crc stable; out_vld&out_rdy -> RUN with lfsr<=INIT, skip counter reloaded, RESULT<=out_crc.
- Latency: out_vld asserted the cycle after the in_last beat handshake.
- Bit step: data bit order MSB-first of beat unless refin (LSB-first). fb=lfsr[W-1]^d; lfsr=((lfsr<<1)&mask_W) ^ (fb ? POLY&mask_W : 0). Bits still under skip counter are consumed without updating lfsr; counter decrements per bit, saturates at 0; skip may straddle beats.
- Result: out_crc = (refout ? bit-reverse over W bits : lfsr) ^ XOROUT, masked to W.
- len=0 or len>CW/8 written with en=1: err<=1, en forced 0, state IDLE.
- POLY/INIT/XOROUT/CON(len,ref,skip) writes while busy or done: ignored, err<=1. CON write en=0 any time: abort to IDLE, no out_vld, RESULT unchanged; abort wins over a same-cycle in_last beat.
- Frame shorter than skip: CRC = INIT processed through final XOR only.
- in_vld ignored in IDLE and DONE (in_rdy=0). Reset mid-frame: immediate return to reset values.
- Clock gating of the engine allowed only while en=0 and no register write; functionally invisible.

Decomposition:
- Shared package crc_engine_pkg: register addresses (CON..STATUS), CON field bit positions, state encodings, max-len constant CW/8.
- One sub-module crc_step: combinational DW-bit update (lfsr, poly, mask, data, refin, skip count in -> lfsr, skip count out); instantiated once, loop-unrolled over DW.

Test Plan:
- CRC-8: W=8, POLY 0x07, INIT 0, XOROUT 0, no reflect, "123456789" (0x31..0x39, last on 0x39) -> out_crc 0xF4, out_vld one cycle after last.
- CRC-16/CCITT-FALSE: POLY 0x1021, INIT 0xFFFF, "123456789" -> 0x29B1; hold out_rdy=0 5 cycles -> out_vld/out_crc stable, in_rdy=0; then RESULT reads 0x29B1.
- CRC-32: POLY 0x04C11DB7, INIT/XOROUT 0xFFFFFFFF, refin=refout=1, "123456789" -> 0xCBF43926; second back-to-back frame gives same value.
- Skip: CRC-16 config, skip=2, frame 0xAA,0x55 then "123456789" -> 0x29B1.
- Abort: mid-frame write CON en=0 coincident with in_last beat -> no out_vld, state IDLE, RESULT unchanged; re-enable and rerun -> correct CRC.
- Errors: write CON len=5 en=1 -> err=1, en=0; POLY write during RUN -> ignored, err=1; STATUS write 0x4 -> err=0.

Source files
------------

// File: rtl/crc_engine_pkg.sv
// Shared definitions for the streaming CRC engine: register map, CON field
// positions, FSM state encoding and the maximum CRC length helper.
package crc_engine_pkg;

    localparam int unsigned ADR_CON    = 0;
    localparam int unsigned ADR_POLY   = 1;
    localparam int unsigned ADR_INIT   = 2;
    localparam int unsigned ADR_XOROUT = 3;
    localparam int unsigned ADR_RESULT = 4;
    localparam int unsigned ADR_STATUS = 5;

    localparam int unsigned CON_EN      = 0;
    localparam int unsigned CON_LEN_LO  = 1;
    localparam int unsigned CON_REFIN   = 4;
    localparam int unsigned CON_REFOUT  = 5;
    localparam int unsigned CON_SKIP_LO = 6;

    localparam int unsigned STS_BUSY = 0;
    localparam int unsigned STS_DONE = 1;
    localparam int unsigned STS_ERR  = 2;

    // Skip counter holds up to 3 bytes = 24 bits.
    localparam int unsigned SKIPW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max_len_bytes(input int cw);
        return cw / 8;
    endfunction

endpackage

// File: rtl/crc_engine_step.sv
// Combinational DW-bit CRC update: walks the beat bit by bit, first draining
// the skip counter, then shifting the active-width LFSR.
module crc_step
    import crc_engine_pkg::*;
#(
    parameter int CW = 32,
    parameter int DW = 8
) (
    input  logic [CW-1:0]    lfsr_i,
    input  logic [CW-1:0]    poly_i,
    input  logic [CW-1:0]    mask_i,
    input  logic [DW-1:0]    dat_i,
    input  logic             refin_i,
    input  logic [SKIPW-1:0] skip_i,
    output logic [CW-1:0]    lfsr_o,
    output logic [SKIPW-1:0] skip_o
);

    logic [CW-1:0] top_s;

    assign top_s = mask_i & ~(mask_i >> 1);

    // Unrolled serial update over all DW bits of the beat
    always_comb begin
        logic [CW-1:0]    l_s;
        logic [SKIPW-1:0] s_s;
        logic             d_s;
        logic             fb_s;
        l_s  = lfsr_i;
        s_s  = skip_i;
        d_s  = 1'b0;
        fb_s = 1'b0;
        for (int i = 0; i < DW; i++) begin
            d_s = refin_i ? dat_i[i] : dat_i[DW-1-i];
            if (s_s != '0) begin
                s_s = s_s - SKIPW'(1);
            end else begin
                fb_s = (|(l_s & top_s)) ^ d_s;
                l_s  = ((l_s << 1) & mask_i) ^ (fb_s ? (poly_i & mask_i) : '0);
            end
        end
        lfsr_o = l_s;
        skip_o = s_s;
    end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine configured over the ICB register bus; consumes DW bits
// per accepted beat and presents the frame CRC on a valid/ready result port.
module crc_engine
    import crc_engine_pkg::*;
#(
    parameter int CW = 32,
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          icb_wr,
    input  logic [AW-1:0] icb_wadr,
    input  logic [31:0]   icb_wdat,
    output logic          icb_wack,
    input  logic          icb_rd,
    input  logic [AW-1:0] icb_radr,
    output logic [31:0]   icb_rdat,
    output logic          icb_rack,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    input  logic          in_last,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [CW-1:0] out_crc
);

    localparam int MAXLEN = max_len_bytes(CW);

    state_e           state_q, state_d;
    logic [7:0]       con_q, con_d;
    logic [CW-1:0]    poly_q, poly_d, init_q, init_d, xorout_q, xorout_d;
    logic [CW-1:0]    result_q, result_d, out_crc_q, out_crc_d, lfsr_q, lfsr_d;
    logic [SKIPW-1:0] skip_q, skip_d;
    logic             err_q, err_d;

    logic             en_s, refin_s, refout_s, active_s, len_ok_s, abort_s;
    logic [2:0]       len_s, wdat_len_s;
    logic [SKIPW-1:0] skip_load_s, step_skip_s;
    logic [CW-1:0]    mask_s, step_lfsr_s, rev_full_s, rev_s, final_s;
    logic             wr_con_s, wr_poly_s, wr_init_s, wr_xor_s, wr_sts_s;
    int               sh_s;

    assign en_s        = con_q[CON_EN];
    assign len_s       = con_q[CON_LEN_LO +: 3];
    assign refin_s     = con_q[CON_REFIN];
    assign refout_s    = con_q[CON_REFOUT];
    assign skip_load_s = SKIPW'({con_q[CON_SKIP_LO +: 2], 3'b000});
    assign active_s    = (state_q != ST_IDLE);

    assign wr_con_s   = icb_wr && (icb_wadr == AW'(ADR_CON));
    assign wr_poly_s  = icb_wr && (icb_wadr == AW'(ADR_POLY));
    assign wr_init_s  = icb_wr && (icb_wadr == AW'(ADR_INIT));
    assign wr_xor_s   = icb_wr && (icb_wadr == AW'(ADR_XOROUT));
    assign wr_sts_s   = icb_wr && (icb_wadr == AW'(ADR_STATUS));
    assign wdat_len_s = icb_wdat[CON_LEN_LO +: 3];
    assign len_ok_s   = (wdat_len_s != 3'd0) && (int'(wdat_len_s) <= MAXLEN);
    assign abort_s    = wr_con_s && !icb_wdat[CON_EN];

    // Active-width mask: low 8*len bits set
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < CW; i++) begin
            if (i < 8 * int'(len_s)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    crc_step #(.CW(CW), .DW(DW)) u_step (
        .lfsr_i  (lfsr_q),
        .poly_i  (poly_q),
        .mask_i  (mask_s),
        .dat_i   (in_dat),
        .refin_i (refin_s),
        .skip_i  (skip_q),
        .lfsr_o  (step_lfsr_s),
        .skip_o  (step_skip_s)
    );

    // Reflection over the active width is a full reversal shifted back down
    always_comb begin
        rev_full_s = '0;
        for (int i = 0; i < CW; i++) begin
            rev_full_s[i] = step_lfsr_s[CW-1-i];
        end
    end

    assign sh_s    = (8 * int'(len_s) <= CW) ? (CW - 8 * int'(len_s)) : 0;
    assign rev_s   = rev_full_s >> sh_s;
    assign final_s = ((refout_s ? rev_s : step_lfsr_s) ^ xorout_q) & mask_s;

    // Register writes and FSM next state; error set wins over a same-cycle clear
    always_comb begin
        state_d   = state_q;
        con_d     = con_q;
        poly_d    = poly_q;
        init_d    = init_q;
        xorout_d  = xorout_q;
        result_d  = result_q;
        out_crc_d = out_crc_q;
        lfsr_d    = lfsr_q;
        skip_d    = skip_q;
        err_d     = err_q;

        if (wr_sts_s && icb_wdat[STS_ERR]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (wr_con_s) begin
            if (!icb_wdat[CON_EN]) begin
                con_d = icb_wdat[7:0];
            end else if (active_s) begin
                err_d = 1'b1;
            end else if (!len_ok_s) begin
                con_d = {icb_wdat[7:1], 1'b0};
                err_d = 1'b1;
            end else begin
                con_d = icb_wdat[7:0];
            end
        end else begin
            con_d = con_q;
        end

        if ((wr_poly_s || wr_init_s || wr_xor_s) && active_s) begin
            err_d = 1'b1;
        end else if (wr_poly_s) begin
            poly_d = icb_wdat[CW-1:0];
        end else if (wr_init_s) begin
            init_d = icb_wdat[CW-1:0];
        end else if (wr_xor_s) begin
            xorout_d = icb_wdat[CW-1:0];
        end else begin
            poly_d = poly_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_s) begin
                    state_d = ST_RUN;
                    lfsr_d  = init_q & mask_s;
                    skip_d  = skip_load_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_vld) begin
                    lfsr_d = step_lfsr_s;
                    skip_d = step_skip_s;
                    if (in_last) begin
                        state_d   = ST_DONE;
                        out_crc_d = final_s;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_rdy) begin
                    state_d  = ST_RUN;
                    lfsr_d   = init_q & mask_s;
                    skip_d   = skip_load_s;
                    result_d = out_crc_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_s) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end else begin
            result_d = result_d;
        end
    end

    // State and configuration registers
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q   <= ST_IDLE;
            con_q     <= 8'd0;
            poly_q    <= '0;
            init_q    <= '0;
            xorout_q  <= '0;
            result_q  <= '0;
            out_crc_q <= '0;
            lfsr_q    <= '0;
            skip_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            con_q     <= con_d;
            poly_q    <= poly_d;
            init_q    <= init_d;
            xorout_q  <= xorout_d;
            result_q  <= result_d;
            out_crc_q <= out_crc_d;
            lfsr_q    <= lfsr_d;
            skip_q    <= skip_d;
            err_q     <= err_d;
        end
    end

    // Read mux, combinational from registers
    always_comb begin
        icb_rdat = 32'd0;
        case (icb_radr)
            AW'(ADR_CON):    icb_rdat = {24'd0, con_q};
            AW'(ADR_POLY):   icb_rdat = 32'(poly_q);
            AW'(ADR_INIT):   icb_rdat = 32'(init_q);
            AW'(ADR_XOROUT): icb_rdat = 32'(xorout_q);
            AW'(ADR_RESULT): icb_rdat = 32'(result_q);
            AW'(ADR_STATUS): icb_rdat = {29'd0, err_q, state_q == ST_DONE, state_q == ST_RUN};
            default:         icb_rdat = 32'd0;
        endcase
    end

    assign icb_wack = icb_wr;
    assign icb_rack = icb_rd;
    assign in_rdy   = (state_q == ST_RUN);
    assign out_vld  = (state_q == ST_DONE);
    assign out_crc  = out_crc_q;

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: directed CRC catalogue cases plus random
// configurations checked against a polynomial-division reference model.
module tb_crc_engine;

    localparam int CW = 32;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_;
    logic          icb_wr, icb_rd, icb_wack, icb_rack;
    logic [AW-1:0] icb_wadr, icb_radr;
    logic [31:0]   icb_wdat, icb_rdat;
    logic          in_vld, in_rdy, in_last, out_vld, out_rdy;
    logic [DW-1:0] in_dat;
    logic [CW-1:0] out_crc;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] cur_con;

    always #5 clk = ~clk;

    crc_engine #(.CW(CW), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_(rst_),
        .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack),
        .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_crc(out_crc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of (INIT*x^n + M*x^W) mod P, M = message bits after skip.
    function automatic logic [31:0] model(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xo,
                                          input bit refin, input bit refout, input int skip,
                                          input logic [7:0] msg[$]);
        bit m[$];
        bit d[$];
        int n;
        logic [31:0] r, rr, mask;
        foreach (msg[i]) for (int j = 0; j < 8; j++) m.push_back(refin ? msg[i][j] : msg[i][7-j]);
        for (int k = 0; k < skip * 8 && m.size() > 0; k++) void'(m.pop_front());
        n = m.size();
        for (int k = 0; k < n + w; k++) begin
            bit v;
            v = (k < n) ? m[k] : 1'b0;
            if (k < w) v = v ^ init[w-1-k];
            d.push_back(v);
        end
        for (int k = 0; k < n; k++)
            if (d[k]) for (int j = 1; j <= w; j++) d[k+j] = d[k+j] ^ poly[w-j];
        r = '0;
        for (int j = 0; j < w; j++) r[w-1-j] = d[n+j];
        rr = r;
        if (refout) begin
            rr = '0;
            for (int j = 0; j < w; j++) rr[j] = r[w-1-j];
        end
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (rr ^ xo) & mask;
    endfunction

    task automatic wr(input int adr, input logic [31:0] dat);
        icb_wr = 1'b1; icb_wadr = AW'(adr); icb_wdat = dat;
        @(negedge clk);
        icb_wr = 1'b0;
    endtask

    task automatic rd(input int adr, output logic [31:0] dat);
        icb_rd = 1'b1; icb_radr = AW'(adr);
        #1;
        dat = icb_rdat;
        icb_rd = 1'b0;
    endtask

    task automatic cfg(input int len, input bit refin, input bit refout, input int skip,
                       input logic [31:0] poly, input logic [31:0] init, input logic [31:0] xo);
        cur_con = {24'd0, 2'(skip), refout, refin, 3'(len), 1'b0};
        wr(0, cur_con); wr(1, poly); wr(2, init); wr(3, xo); wr(0, cur_con | 32'd1);
    endtask

    task automatic send(input logic [7:0] msg[$], input bit with_last);
        foreach (msg[i]) begin
            int t;
            t = 0;
            in_vld = 1'b1; in_dat = msg[i]; in_last = with_last && (i == msg.size() - 1);
            while (!in_rdy && t < 50) begin @(negedge clk); t++; end
            chk("in_rdy_wait", 32'(in_rdy), 32'd1);
            @(negedge clk);
        end
        in_vld = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [31:0] exp, input int hold);
        int t;
        t = 0;
        while (!out_vld && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_vld"}, 32'(out_vld), 32'd1);
        chk(tag, 32'(out_crc), exp);
        in_vld = 1'b1; in_dat = 8'hA5; in_last = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, 32'(out_vld), 32'd1);
            chk({tag, "_hold_crc"}, 32'(out_crc), exp);
            chk({tag, "_hold_rdy"}, 32'(in_rdy), 32'd0);
        end
        in_vld = 1'b0; in_last = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, exp, p, iv, xo;
        logic [7:0]  m9[$], mq[$];
        int len, skip, nb;
        bit ri, ro;

        m9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_ = 1'b1; icb_wr = 1'b0; icb_rd = 1'b0; icb_wadr = '0; icb_radr = '0; icb_wdat = '0;
        in_vld = 1'b0; in_dat = '0; in_last = 1'b0; out_rdy = 1'b0; cur_con = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_crc", 32'(out_crc), 32'd0);
        rst_ = 1'b0;
        @(negedge clk);
        rd(0, r); chk("rst_con", r, 32'd0);
        rd(4, r); chk("rst_result", r, 32'd0);
        rd(5, r); chk("rst_status", r, 32'd0);
        rd(9, r); chk("unmapped_rd", r, 32'd0);

        // CRC-8 with latency check
        cfg(1, 1'b0, 1'b0, 0, 32'h07, 32'h0, 32'h0);
        send(m9, 1'b1);
        chk("crc8_latency", 32'(out_vld), 32'd1);
        collect("crc8", 32'hF4, 0);

        // CRC-16/CCITT-FALSE with back-pressure
        cfg(2, 1'b0, 1'b0, 0, 32'h1021, 32'hFFFF, 32'h0);
        send(m9, 1'b1);
        rd(5, r); chk("status_done", r, 32'h2);
        collect("crc16", 32'h29B1, 5);
        rd(4, r); chk("crc16_result", r, 32'h29B1);

        // CRC-32, two back-to-back frames
        cfg(4, 1'b1, 1'b1, 0, 32'h04C11DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(m9, 1'b1);
        collect("crc32_a", 32'hCBF43926, 0);
        send(m9, 1'b1);
        collect("crc32_b", 32'hCBF43926, 0);

        // Leading-byte skip, then frame shorter than skip
        cfg(2, 1'b0, 1'b0, 2, 32'h1021, 32'hFFFF, 32'h0);
        mq = '{8'hAA, 8'h55, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(mq, 1'b1);
        collect("crc16_skip", 32'h29B1, 0);
        cfg(2, 1'b0, 1'b0, 3, 32'h1021, 32'hFFFF, 32'h00F0);
        mq = '{8'h12, 8'h34};
        send(mq, 1'b1);
        collect("short_skip", 32'hFF0F, 0);

        // Abort coincident with the last beat
        cfg(2, 1'b0, 1'b0, 0, 32'h1021, 32'hFFFF, 32'h0);
        mq = m9[0:7];
        send(mq, 1'b0);
        in_vld = 1'b1; in_dat = 8'h39; in_last = 1'b1;
        icb_wr = 1'b1; icb_wadr = AW'(0); icb_wdat = cur_con;
        @(negedge clk);
        icb_wr = 1'b0; in_vld = 1'b0; in_last = 1'b0;
        repeat (3) begin
            chk("abort_no_vld", 32'(out_vld), 32'd0);
            @(negedge clk);
        end
        rd(5, r); chk("abort_status", r, 32'd0);
        rd(4, r); chk("abort_result", r, 32'hFF0F);
        wr(0, cur_con | 32'd1);
        send(m9, 1'b1);
        collect("abort_rerun", 32'h29B1, 0);

        // Error handling
        wr(0, 32'd0);
        wr(0, 32'h0B);
        rd(0, r); chk("len5_en", r & 32'd1, 32'd0);
        rd(5, r); chk("len5_err", r, 32'h4);
        wr(5, 32'h4);
        rd(5, r); chk("err_clear", r, 32'd0);
        wr(0, 32'h01);
        rd(5, r); chk("len0_err", r, 32'h4);
        wr(5, 32'h4);
        cfg(2, 1'b0, 1'b0, 0, 32'h1021, 32'hFFFF, 32'h0);
        @(negedge clk);
        rd(5, r); chk("status_busy", r, 32'h1);
        wr(1, 32'h1234);
        rd(1, r); chk("poly_locked", r, 32'h1021);
        rd(5, r); chk("poly_busy_err", r, 32'h5);
        wr(5, 32'h4);
        rd(5, r); chk("err_clear2", r, 32'h1);

        // Random configurations against the model
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 4); skip = $urandom_range(0, 3); nb = $urandom_range(1, 10);
            ri = 1'($urandom); ro = 1'($urandom);
            p = $urandom | 32'd1; iv = $urandom; xo = $urandom;
            mq.delete();
            for (int k = 0; k < nb; k++) mq.push_back(8'($urandom));
            exp = model(8 * len, p, iv, xo, ri, ro, skip, mq);
            cfg(len, ri, ro, skip, p, iv, xo);
            send(mq, 1'b1);
            collect("rand_crc", exp, $urandom_range(0, 2));
            rd(4, r); chk("rand_result", r, exp);
        end

        // Reset in the middle of a frame
        cfg(1, 1'b0, 1'b0, 0, 32'h07, 32'h0, 32'h0);
        mq = m9[0:2];
        send(mq, 1'b0);
        rst_ = 1'b1;
        #1;
        chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
        chk("midrst_out_crc", 32'(out_crc), 32'd0);
        rd(0, r); chk("midrst_con", r, 32'd0);
        rd(4, r); chk("midrst_result", r, 32'd0);
        @(negedge clk);
        rst_ = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
